// File: rtl/n64_vinfo_ext.sv
// n64_vinfo_ext: video-bus timing extraction for the N64 digital video bus.
// Tracks the 4-word cycle (sync, R, G, B), measures lines per frame to
// classify NTSC/PAL, and detects 480i from the nHSYNC level at each vsync edge.
// Optional macro VMODE_HYST_EN: vmode only changes after two consecutive
// RUN-state frames agree on the new candidate.
// Handshake: none; nDSYNC=0 marks the sync word, every other word is ignored.

module n64_vinfo_ext #(
    parameter int LCNT_W = 10,
    parameter int PAL_TH = 288
) (
    input  logic       VCLK,
    input  logic       nRST,
    input  logic       nDSYNC,
    input  logic [3:0] D_i,
    output logic [1:0] data_cnt,
    output logic       vmode,
    output logic       n64_480i,
    output logic       FrameID,
    output logic       new_frame,
    output logic [3:0] sync_o
);

    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;

    // Threshold widened by one bit so a PAL_TH above the counter range never truncates.
    localparam logic [LCNT_W:0] PAL_THR = (LCNT_W + 1)'(PAL_TH);

    logic [1:0]        state;
    logic [LCNT_W-1:0] line_cnt;
    logic              last_fid;
    logic              vs_fall;
    logic              hs_fall;
    logic              cand;
    logic              cnt_max;

    // Edges exist only on sync words; sync_o holds the previous sync nibble.
    assign vs_fall = !nDSYNC && sync_o[3] && !D_i[3];
    assign hs_fall = !nDSYNC && sync_o[1] && !D_i[1];
    assign cnt_max = &line_cnt;
    // Candidate uses the count before the vsync edge clears it.
    assign cand    = ({1'b0, line_cnt} >= PAL_THR);

    // Capture the sync nibble on every sync word.
    always_ff @(posedge VCLK) begin
        if (!nRST)
            sync_o <= 4'hF;
        else if (!nDSYNC)
            sync_o <= D_i;
    end

    // Word phase: 01 after a sync word, then count up and wrap to 00 (invalid).
    always_ff @(posedge VCLK) begin
        if (!nRST)
            data_cnt <= 2'b00;
        else if (!nDSYNC)
            data_cnt <= 2'b01;
        else if (data_cnt != 2'b00)
            data_cnt <= data_cnt + 2'b01;
    end

    // Line counter: cleared by vsync (wins over a coincident hsync), saturating.
    always_ff @(posedge VCLK) begin
        if (!nRST)
            line_cnt <= '0;
        else if (vs_fall)
            line_cnt <= '0;
        else if (hs_fall && !cnt_max)
            line_cnt <= line_cnt + 1'b1;
    end

    // Frame FSM plus field-parity tracking, FrameID and the frame strobe.
    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            state     <= ST_INIT;
            last_fid  <= 1'b0;
            n64_480i  <= 1'b0;
            FrameID   <= 1'b0;
            new_frame <= 1'b0;
        end else begin
            new_frame <= vs_fall;
            if (vs_fall) begin
                FrameID <= D_i[1];
                case (state)
                    ST_INIT:  state <= ST_ARMED;
                    ST_ARMED: begin
                        state    <= ST_RUN;
                        last_fid <= D_i[1];
                    end
                    ST_RUN: begin
                        n64_480i <= (D_i[1] != last_fid);
                        last_fid <= D_i[1];
                    end
                    default:  state <= ST_INIT;
                endcase
            end
        end
    end

`ifdef VMODE_HYST_EN
    logic pending;

    // vmode with hysteresis: a differing RUN candidate must repeat once before it is taken.
    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            vmode   <= 1'b0;
            pending <= 1'b0;
        end else if (vs_fall) begin
            if (state == ST_ARMED) begin
                vmode   <= cand;
                pending <= 1'b0;
            end else if (state == ST_RUN) begin
                if (cand == vmode) begin
                    pending <= 1'b0;
                end else if (pending) begin
                    vmode   <= cand;
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end
`else
    // vmode follows each measured frame's candidate directly.
    always_ff @(posedge VCLK) begin
        if (!nRST)
            vmode <= 1'b0;
        else if (vs_fall && (state == ST_ARMED || state == ST_RUN))
            vmode <= cand;
    end
`endif

endmodule

// File: tb/tb_n64_vinfo_ext.sv
// Bench for n64_vinfo_ext: directed frame sequences plus randomized frames,
// checked every cycle against a frame-level reference model.
module tb_n64_vinfo_ext;

    logic       VCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       nDSYNC = 1'b1;
    logic [3:0] D_i = 4'hF;
    logic [1:0] data_cnt;
    logic       vmode;
    logic       n64_480i;
    logic       FrameID;
    logic       new_frame;
    logic [3:0] sync_o;

    n64_vinfo_ext dut (
        .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i),
        .data_cnt(data_cnt), .vmode(vmode), .n64_480i(n64_480i),
        .FrameID(FrameID), .new_frame(new_frame), .sync_o(sync_o)
    );

    // Clock
    always #5 VCLK = ~VCLK;

    int total = 0;
    int bad = 0;

    // Reference model state
    int         since_sync;   // words since the last sync word (99 = none)
    logic [3:0] exp_sync;
    logic [1:0] exp_dc;
    logic       exp_vmode, exp_480i, exp_fid, exp_nf;
    logic       m_last_fid;
    int         m_edges;      // vsync edges since reset, capped at 2
    int         m_lines;      // lines seen in the current frame
    logic       m_prev_cand;
    logic       m_prev_valid; // previous edge was a RUN-state edge

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        since_sync = 99; exp_sync = 4'hF;
        exp_vmode = 0; exp_480i = 0; exp_fid = 0; exp_nf = 0;
        m_last_fid = 0; m_edges = 0; m_lines = 0;
        m_prev_cand = 0; m_prev_valid = 0;
    endtask

    // A frame closes at a vsync edge; classify it from the number of lines it held.
    task automatic frame_edge(input logic fid);
        int   lines_sat;
        logic cand;
        lines_sat = (m_lines > 1023) ? 1023 : m_lines;
        cand = (lines_sat >= 288);
        if (m_edges == 1) begin
            exp_vmode = cand;
            m_last_fid = fid;
            m_prev_valid = 0;
        end else if (m_edges >= 2) begin
`ifdef VMODE_HYST_EN
            if (cand != exp_vmode && m_prev_valid && m_prev_cand == cand)
                exp_vmode = cand;
`else
            exp_vmode = cand;
`endif
            m_prev_cand = cand;
            m_prev_valid = 1;
            exp_480i = (fid != m_last_fid);
            m_last_fid = fid;
        end
        exp_fid = fid;
        exp_nf = 1;
        m_lines = 0;
        if (m_edges < 2) m_edges++;
    endtask

    // One VCLK: drive, clock, update the model, compare every output.
    task automatic tick(input logic rst_n, input logic nds, input logic [3:0] d);
        nRST = rst_n; nDSYNC = nds; D_i = d;
        @(posedge VCLK);
        #1;
        exp_nf = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!nds) begin
            if (exp_sync[3] && !d[3])
                frame_edge(d[1]);
            else if (exp_sync[1] && !d[1])
                m_lines++;
            exp_sync = d;
            since_sync = 0;
        end else if (since_sync < 99) begin
            since_sync++;
        end
        exp_dc = (since_sync < 3) ? 2'(since_sync + 1) : 2'b00;
        check("data_cnt", 10'(data_cnt), 10'(exp_dc));
        check("sync_o", 10'(sync_o), 10'(exp_sync));
        check("new_frame", 10'(new_frame), 10'(exp_nf));
        check("vmode", 10'(vmode), 10'(exp_vmode));
        check("n64_480i", 10'(n64_480i), 10'(exp_480i));
        check("FrameID", 10'(FrameID), 10'(exp_fid));
    endtask

    // One line: hsync low word, hsync high word, a few random data words.
    task automatic send_line();
        tick(1, 0, 4'b1101);
        tick(1, 0, 4'b1111);
        repeat ($urandom_range(0, 2)) tick(1, 1, 4'($urandom));
    endtask

    // Vsync edge with the given nHSYNC level, then release.
    task automatic send_vsync(input logic fid);
        tick(1, 0, {1'b0, 1'b1, fid, 1'b1});
        tick(1, 0, 4'hF);
    endtask

    task automatic send_frame(input int n, input logic fid);
        repeat (n) send_line();
        send_vsync(fid);
    endtask

    // Check the strobe right at the edge word, for explicit directed checks.
    task automatic send_frame_chk(input int n, input logic fid, input string tag,
                                  input logic exp_vm);
        repeat (n) send_line();
        tick(1, 0, {1'b0, 1'b1, fid, 1'b1});
        check(tag, 10'(vmode), 10'(exp_vm));
        check("strobe_at_edge", 10'(new_frame), 10'd1);
        tick(1, 0, 4'hF);
        check("strobe_width", 10'(new_frame), 10'd0);
    endtask

    initial begin
        model_reset();
        // Reset
        tick(0, 1, 4'h0);
        tick(0, 0, 4'h0);
        check("rst_data_cnt", 10'(data_cnt), 10'd0);
        check("rst_sync_o", 10'(sync_o), 10'hF);
        check("rst_vmode", 10'(vmode), 10'd0);

        // Word phase: sync every 4th word, then a long gap without sync
        repeat (3) begin
            tick(1, 0, 4'hF);
            repeat (3) tick(1, 1, 4'($urandom));
        end
        tick(1, 0, 4'hF);
        repeat (8) tick(1, 1, 4'($urandom));
        check("gap_data_cnt", 10'(data_cnt), 10'd0);

        // NTSC progressive
        send_frame(20, 1);
        send_frame_chk(263, 1, "ntsc_armed", 1'b0);
        send_frame_chk(263, 1, "ntsc_run", 1'b0);
        check("ntsc_480i", 10'(n64_480i), 10'd0);

        // PAL switch
`ifdef VMODE_HYST_EN
        send_frame_chk(313, 1, "pal_first", 1'b0);
        send_frame_chk(313, 1, "pal_second", 1'b1);
        send_frame(263, 1);
        send_frame(263, 1);
        send_frame_chk(313, 1, "glitch_pal", 1'b0);
        send_frame_chk(263, 1, "glitch_after", 1'b0);
`else
        send_frame_chk(313, 1, "pal_first", 1'b1);
        send_frame_chk(263, 1, "back_ntsc", 1'b0);
`endif

        // 480i: alternating field level, then constant
        send_frame(263, 0);
        send_frame(263, 1);
        check("fid_1", 10'(FrameID), 10'd1);
        check("480i_on", 10'(n64_480i), 10'd1);
        send_frame(263, 0);
        check("fid_0", 10'(FrameID), 10'd0);
        check("480i_on2", 10'(n64_480i), 10'd1);
        send_frame(263, 0);
        check("480i_off", 10'(n64_480i), 10'd0);

        // Saturation: long frames classify PAL
        send_frame(263, 1);
        send_frame(1100, 1);
        send_frame_chk(1100, 1, "sat_pal", 1'b1);

        // Coincident hsync/vsync word opens a frame; that line is not counted
        send_frame(263, 1);
        send_frame(263, 1);
        send_frame(263, 0);
        send_frame_chk(287, 1, "below_th", 1'b0);
        send_frame(288, 1);
        send_frame_chk(288, 1, "at_th", 1'b1);

        // Random frames near the threshold with random field levels
        repeat (8) send_frame($urandom_range(270, 310), 1'($urandom));

        // Mid-frame reset while PAL
        send_frame(300, 1);
        send_frame(300, 1);
        repeat (40) send_line();
        tick(0, 1, 4'($urandom));
        check("mrst_vmode", 10'(vmode), 10'd0);
        check("mrst_fid", 10'(FrameID), 10'd0);
        check("mrst_480i", 10'(n64_480i), 10'd0);
        check("mrst_sync_o", 10'(sync_o), 10'hF);
        check("mrst_data_cnt", 10'(data_cnt), 10'd0);
        send_frame_chk(300, 1, "post_rst_init", 1'b0);
        send_frame_chk(300, 1, "post_rst_armed", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
